bar_graph_control: RTL and testbench

- Sequencer that renders NUM_BARS vertical bars into the 640x480 VGA frame.
- Latches one height per bar on start, then raster-scans each bar's full MAX_H x BAR_W box: pixels below the bar height get the bar colour, pixels above get the background colour. Redrawing therefore also erases the previous bar.
- Drives the pixel plotter through a plot/plot_ready handshake and reports busy/done to the top-level game FSM.

---
 rtl/bar_graph_control.sv | 150 +++++++++++++++
 tb/tb_bar_graph_control.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/bar_graph_control.sv
// Bar-graph sequencer: raster-scans NUM_BARS boxes into a 640x480 frame through a plot handshake.
// Define BAR_OUTLINE_EN to draw each non-empty bar's top row in the inverted bar colour.
module bar_graph_control #(
  parameter int unsigned NUM_BARS = 4,
  parameter int unsigned BAR_W    = 32,
  parameter int unsigned MAX_H    = 200,
  parameter int unsigned GAP      = 8,
  parameter int unsigned BASE_X   = 40,
  parameter int unsigned BASE_Y   = 440
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [NUM_BARS*8-1:0] heights,
  input  logic [2:0]            bar_colour,
  input  logic [2:0]            bg_colour,
  input  logic                  plot_ready,
  output logic [9:0]            x_coord,
  output logic [8:0]            y_coord,
  output logic [2:0]            colour,
  output logic                  plot,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned BarW = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;
  localparam int unsigned OxW  = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam int unsigned OyW  = (MAX_H > 1) ? $clog2(MAX_H) : 1;

  localparam logic [BarW-1:0] LastBar = BarW'(NUM_BARS - 1);
  localparam logic [OxW-1:0]  LastOx  = OxW'(BAR_W - 1);
  localparam logic [OyW-1:0]  LastOy  = OyW'(MAX_H - 1);
  localparam logic [7:0]      MaxH8   = 8'(MAX_H);
  localparam logic [9:0]      BaseX10 = 10'(BASE_X);
  localparam logic [9:0]      Pitch10 = 10'(BAR_W + GAP);
  localparam logic [8:0]      BaseY9  = 9'(BASE_Y);

  typedef enum logic [2:0] {StIdle, StLoad, StScan, StNext, StDone} state_e;

  state_e          state_q, state_d;
  logic [BarW-1:0] bar_q, bar_d;
  logic [OxW-1:0]  ox_q, ox_d;
  logic [OyW-1:0]  oy_q, oy_d;
  logic [7:0]      h_q [NUM_BARS];
  logic [7:0]      h_d [NUM_BARS];
  logic [2:0]      bar_col_q, bar_col_d;
  logic [2:0]      bg_col_q, bg_col_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      bar_q     <= '0;
      ox_q      <= '0;
      oy_q      <= '0;
      bar_col_q <= '0;
      bg_col_q  <= '0;
      for (int unsigned i = 0; i < NUM_BARS; i++) h_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      bar_q     <= bar_d;
      ox_q      <= ox_d;
      oy_q      <= oy_d;
      bar_col_q <= bar_col_d;
      bg_col_q  <= bg_col_d;
      for (int unsigned i = 0; i < NUM_BARS; i++) h_q[i] <= h_d[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    bar_d     = bar_q;
    ox_d      = ox_q;
    oy_d      = oy_q;
    bar_col_d = bar_col_q;
    bg_col_d  = bg_col_q;
    h_d       = h_q;
    unique case (state_q)
      StIdle: if (start) state_d = StLoad;
      StLoad: begin
        for (int unsigned i = 0; i < NUM_BARS; i++) begin
          h_d[i] = (heights[8*i +: 8] > MaxH8) ? MaxH8 : heights[8*i +: 8];
        end
        bar_col_d = bar_colour;
        bg_col_d  = bg_colour;
        bar_d     = '0;
        ox_d      = '0;
        oy_d      = '0;
        state_d   = StScan;
      end
      StScan: begin
        // plot is always high here, so acceptance is plot_ready alone
        if (plot_ready) begin
          if (ox_q == LastOx) begin
            ox_d = '0;
            if (oy_q == LastOy) begin
              oy_d    = '0;
              state_d = StNext;
            end else begin
              oy_d = oy_q + 1'b1;
            end
          end else begin
            ox_d = ox_q + 1'b1;
          end
        end
      end
      StNext: begin
        if (bar_q == LastBar) begin
          state_d = StDone;
        end else begin
          bar_d   = bar_q + 1'b1;
          ox_d    = '0;
          oy_d    = '0;
          state_d = StScan;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  logic       scan;
  logic [9:0] x_calc;
  logic [8:0] y_calc;
  logic [7:0] cur_h;
  logic [8:0] oy_ext, h_ext;
  logic [2:0] pix_col;

  assign scan   = (state_q == StScan);
  assign x_calc = BaseX10 + 10'(bar_q) * Pitch10 + 10'(ox_q);
  assign y_calc = BaseY9 - 9'(oy_q);
  assign cur_h  = h_q[bar_q];
  assign oy_ext = 9'(oy_q);
  assign h_ext  = 9'(cur_h);

  always_comb begin
    pix_col = (oy_ext < h_ext) ? bar_col_q : bg_col_q;
`ifdef BAR_OUTLINE_EN
    if ((cur_h != 8'd0) && (oy_ext == h_ext - 9'd1)) pix_col = ~bar_col_q;
`endif
  end

  // Outputs are zero outside SCAN so reset and idle present a blank plotter interface
  assign x_coord = scan ? x_calc : '0;
  assign y_coord = scan ? y_calc : '0;
  assign colour  = scan ? pix_col : '0;
  assign plot    = scan;
  assign busy    = (state_q == StLoad) || (state_q == StScan) || (state_q == StNext);
  assign done    = (state_q == StDone);

endmodule

// File: tb/tb_bar_graph_control.sv
// Directed bench for bar_graph_control: reset mid-scan, basic draw, clamp, backpressure,
// start-while-busy; expectations follow BAR_OUTLINE_EN when defined.
module tb_bar_graph_control;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [31:0] heights;
  logic [2:0]  bar_colour, bg_colour;
  logic        plot_ready;
  logic [9:0]  x_coord;
  logic [8:0]  y_coord;
  logic [2:0]  colour;
  logic        plot, busy, done;

  bar_graph_control dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .heights    (heights),
    .bar_colour (bar_colour),
    .bg_colour  (bg_colour),
    .plot_ready (plot_ready),
    .x_coord    (x_coord),
    .y_coord    (y_coord),
    .colour     (colour),
    .plot       (plot),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  // Per-run observations
  int         acc_cnt, pix_err, stab_err, done_cnt, done_cyc, first_plot_cyc;
  int         bc_cnt [4];
  int         y_min, reset_hit, busy_c1, busy_at_done;
  logic [9:0] px0_x, px1_x, bar1_x;
  logic [8:0] px0_y, bar1_y;
  logic [2:0] c431, c432;

  function automatic logic [2:0] exp_col(input int oy, input int h, input logic [2:0] bc,
                                         input logic [2:0] bg);
`ifdef BAR_OUTLINE_EN
    if (h != 0 && oy == h - 1) return ~bc;
`endif
    return (oy < h) ? bc : bg;
  endfunction

  task automatic run_draw(input logic [31:0] hts, input logic [2:0] bc, input logic [2:0] bg,
                          input int ready_pct, input int poke_at, input int reset_at);
    int bar, ox, oy, cyc, post, h[4];
    bit hold_valid, stop;
    logic [22:0] hold_val;
    logic [9:0] ex;
    logic [8:0] ey;
    bar = 0; ox = 0; oy = 0; cyc = 0; post = 0; hold_valid = 0; stop = 0; hold_val = '0;
    acc_cnt = 0; pix_err = 0; stab_err = 0; done_cnt = 0; done_cyc = -1; first_plot_cyc = -1;
    y_min = 1000; reset_hit = 0; busy_c1 = 0; busy_at_done = 1;
    px0_x = '0; px0_y = '0; px1_x = '0; bar1_x = '0; bar1_y = '0; c431 = '0; c432 = '0;
    for (int i = 0; i < 4; i++) begin
      bc_cnt[i] = 0;
      h[i] = (int'(hts[8*i +: 8]) > 200) ? 200 : int'(hts[8*i +: 8]);
    end
    @(negedge clk);
    heights = hts; bar_colour = bc; bg_colour = bg; start = 1'b1; plot_ready = 1'b1;
    while (!stop && cyc < 60000 && post < 5) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == 1) busy_c1 = busy;
      if (reset_at >= 0 && plot && bar == 1 && oy * 32 + ox == reset_at) begin
        resetn = 1'b0;
        #1;
        reset_hit = 1;
        check("reset mid-scan plot", plot, 0);
        check("reset mid-scan busy", busy, 0);
        check("reset mid-scan x", x_coord, 0);
        stop = 1;
      end else begin
        if (hold_valid && {plot, x_coord, y_coord, colour} !== hold_val) stab_err++;
        if (done) begin
          if (done_cnt == 0) begin
            done_cyc = cyc;
            busy_at_done = busy;
          end
          done_cnt++;
        end
        if (done_cnt > 0) post++;
        if (plot && first_plot_cyc < 0) first_plot_cyc = cyc;
        plot_ready = ($urandom_range(99) < ready_pct);
        if (plot && plot_ready && bar < 4) begin
          ex = 10'(40 + bar * 40 + ox);
          ey = 9'(440 - oy);
          if (x_coord !== ex || y_coord !== ey || colour !== exp_col(oy, h[bar], bc, bg))
            pix_err++;
          if (colour == bc) bc_cnt[bar]++;
          if (int'(y_coord) < y_min) y_min = int'(y_coord);
          if (acc_cnt == 0) begin px0_x = x_coord; px0_y = y_coord; end
          if (acc_cnt == 1) px1_x = x_coord;
          if (acc_cnt == 6400) begin bar1_x = x_coord; bar1_y = y_coord; end
          if (bar == 1 && ox == 0 && oy == 9) c431 = colour;
          if (bar == 1 && ox == 0 && oy == 8) c432 = colour;
          acc_cnt++;
          if (acc_cnt == poke_at) begin
            start = 1'b1; heights = '0; bar_colour = ~bc; bg_colour = ~bg;
          end
          if (ox == 31) begin
            ox = 0;
            if (oy == 199) begin oy = 0; bar++; end
            else oy++;
          end else begin
            ox++;
          end
        end
        hold_valid = plot && !plot_ready;
        hold_val   = {plot, x_coord, y_coord, colour};
      end
    end
    plot_ready = 1'b1;
    start = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; heights = '0; bar_colour = '0; bg_colour = '0;
    plot_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset plot", plot, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset xyc", {x_coord, y_coord, colour}, 0);
    resetn = 1'b1;

    // Reset at pixel 1000 of bar 1
    run_draw({8'd0, 8'd1, 8'd100, 8'd200}, 3'b010, 3'b001, 100, -1, 1000);
    check("reset reached bar1 px1000", reset_hit, 1);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    check("post-reset idle plot", plot, 0);
    check("post-reset idle busy", busy, 0);

    // Basic draw, with a start pulse and input changes in the middle of bar 2
    run_draw({8'd0, 8'd1, 8'd100, 8'd200}, 3'b010, 3'b001, 100, 2 * 6400 + 500, -1);
    check("busy after start", busy_c1, 1);
    check("first plot latency", first_plot_cyc, 2);
    check("pixel0 x", px0_x, 40);
    check("pixel0 y", px0_y, 440);
    check("pixel1 x", px1_x, 41);
    check("bar1 first x", bar1_x, 80);
    check("bar1 first y", bar1_y, 440);
`ifdef BAR_OUTLINE_EN
    check("bar0 bar pixels", bc_cnt[0], 6368);
    check("bar1 bar pixels", bc_cnt[1], 3168);
    check("bar2 bar pixels", bc_cnt[2], 0);
`else
    check("bar0 bar pixels", bc_cnt[0], 6400);
    check("bar1 bar pixels", bc_cnt[1], 3200);
    check("bar2 bar pixels", bc_cnt[2], 32);
`endif
    check("bar3 bar pixels", bc_cnt[3], 0);
    check("basic pixel errors", pix_err, 0);
    check("basic accepted", acc_cnt, 25600);
    check("basic done cycle", done_cyc, 25606);
    check("basic done pulses", done_cnt, 1);
    check("busy low at done", busy_at_done, 0);

    // Backpressure with a clamped bar 0 and a height-10 bar 1
    run_draw({8'd7, 8'd200, 8'd10, 8'd255}, 3'b100, 3'b000, 75, -1, -1);
    check("bp pixel errors", pix_err, 0);
    check("bp hold stability", stab_err, 0);
    check("bp accepted", acc_cnt, 25600);
    check("bp done pulses", done_cnt, 1);
    check("bp slower than ready", done_cyc > 25606, 1);
    check("clamp min y", y_min, 241);
`ifdef BAR_OUTLINE_EN
    check("clamp bar0 pixels", bc_cnt[0], 6368);
    check("cap row y431", c431, 3'b011);
`else
    check("clamp bar0 pixels", bc_cnt[0], 6400);
    check("cap row y431", c431, 3'b100);
`endif
    check("row y432", c432, 3'b100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
